// File: rtl/x74xx191.sv
// 4-bit synchronous presettable up/down binary counter (74xx191 equivalent).
// Optional ripple-clock output enabled by defining X74XX191_RC_N_EN; otherwise RC_N is tied high.
`timescale 1ns/1ps

module x74xx191 #(
   parameter logic [3:0] RESET_VALUE = 4'b0000
) (
   input  logic CP,
   input  logic MR_N,
   input  logic P0,
   input  logic P1,
   input  logic P2,
   input  logic P3,
   input  logic PL_N,
   input  logic CE_N,
   input  logic U_D,
   output logic Q0,
   output logic Q1,
   output logic Q2,
   output logic Q3,
   output logic TC,
   output logic RC_N
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = '0;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] load_val;
   logic             at_max;
   logic             at_min;

   assign load_val = {P3, P2, P1, P0};

   // Load beats count; count direction from U_D; otherwise hold.
   always_comb begin
      count_d = count_q;
      if (!PL_N) begin
         count_d = load_val;
      end else if (!CE_N) begin
         if (U_D) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CP or negedge MR_N) begin
      if (!MR_N) begin
         count_q <= RESET_VALUE;
      end else begin
         count_q <= count_d;
      end
   end

   assign Q0 = count_q[0];
   assign Q1 = count_q[1];
   assign Q2 = count_q[2];
   assign Q3 = count_q[3];

   // Terminal count follows the live direction input, independent of enable.
   assign at_max = (count_q == CNT_MAX);
   assign at_min = (count_q == CNT_MIN);
   assign TC     = U_D ? at_min : at_max;

`ifdef X74XX191_RC_N_EN
   assign RC_N = ~(TC & ~CE_N & ~CP);
`else
   assign RC_N = 1'b1;
`endif

endmodule

// File: tb/tb_x74xx191.sv
// Bench for x74xx191: two stages cascaded into an 8-bit up/down counter,
// checked against an 8-bit arithmetic model through a scoreboard queue.
`timescale 1ns/1ps

module tb_x74xx191;

   typedef struct {
      logic [7:0] q;
      logic       tc_lo;
      logic       tc_hi;
      logic       rc_n_lo;
   } exp_t;

   logic       cp;
   logic       mr_n;
   logic [7:0] p;
   logic       pl_n;
   logic       ce_n;
   logic       u_d;
   logic       ce_n_hi;
   logic       q0_lo, q1_lo, q2_lo, q3_lo, tc_lo, rc_n_lo;
   logic       q0_hi, q1_hi, q2_hi, q3_hi, tc_hi, rc_n_hi;
   logic [7:0] q8;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] model_v;
   exp_t       sb[$];

   assign ce_n_hi = ~(tc_lo & ~ce_n);
   assign q8      = {q3_hi, q2_hi, q1_hi, q0_hi, q3_lo, q2_lo, q1_lo, q0_lo};

   x74xx191 u_lo (
      .CP(cp), .MR_N(mr_n),
      .P0(p[0]), .P1(p[1]), .P2(p[2]), .P3(p[3]),
      .PL_N(pl_n), .CE_N(ce_n), .U_D(u_d),
      .Q0(q0_lo), .Q1(q1_lo), .Q2(q2_lo), .Q3(q3_lo),
      .TC(tc_lo), .RC_N(rc_n_lo)
   );

   x74xx191 u_hi (
      .CP(cp), .MR_N(mr_n),
      .P0(p[4]), .P1(p[5]), .P2(p[6]), .P3(p[7]),
      .PL_N(pl_n), .CE_N(ce_n_hi), .U_D(u_d),
      .Q0(q0_hi), .Q1(q1_hi), .Q2(q2_hi), .Q3(q3_hi),
      .TC(tc_hi), .RC_N(rc_n_hi)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_rc_n(input logic tc, input logic ce);
`ifdef X74XX191_RC_N_EN
      return ~(tc & ~ce);
`else
      return 1'b1 | tc | ce;
`endif
   endfunction

   // Drive one cycle's controls just after the falling edge and queue the result
   // the next rising edge (or the asynchronous reset) must produce.
   task automatic step(input logic mr, input logic pl, input logic ce,
                       input logic ud, input logic [7:0] pv);
      exp_t e;
      @(negedge cp);
      #1;
      mr_n = mr; pl_n = pl; ce_n = ce; u_d = ud; p = pv;
      if (!mr)      model_v = 8'h00;
      else if (!pl) model_v = pv;
      else if (!ce) model_v = ud ? model_v - 8'd1 : model_v + 8'd1;
      e.q       = model_v;
      e.tc_lo   = ud ? (model_v[3:0] == 4'h0) : (model_v[3:0] == 4'hF);
      e.tc_hi   = ud ? (model_v[7:4] == 4'h0) : (model_v[7:4] == 4'hF);
      e.rc_n_lo = exp_rc_n(e.tc_lo, ce);
      sb.push_back(e);
      if (!mr) begin
         #1;
         check("async_reset_immediate", q8, 8'h00);
      end
   endtask

   // Monitor: each falling edge shows the result of the preceding rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge cp);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count",   q8,              e.q);
            check("tc_lo",   8'(tc_lo),       8'(e.tc_lo));
            check("tc_hi",   8'(tc_hi),       8'(e.tc_hi));
            check("rc_n_lo", 8'(rc_n_lo),     8'(e.rc_n_lo));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      mr_n = 1'b0; pl_n = 1'b1; ce_n = 1'b1; u_d = 1'b0; p = 8'h00;
      model_v = 8'h00;
      #3;
      check("reset_count", q8, 8'h00);
      check("reset_tc_up", 8'(tc_lo), 8'h00);
      u_d = 1'b1;
      #1;
      check("reset_tc_down_no_clock", 8'(tc_lo), 8'h01);
      u_d = 1'b0;

      // Async reset mid-cycle from count 9, then TC follows U_D.
      step(1, 0, 1, 0, 8'h09);
      step(0, 1, 1, 0, 8'h00);
      step(0, 1, 1, 1, 8'h00);
      // Load priority over count.
      step(1, 0, 0, 0, 8'h06);
      step(1, 1, 0, 0, 8'h00);
      // Up count through the nibble wrap.
      step(1, 0, 1, 0, 8'h0D);
      repeat (3) step(1, 1, 0, 0, 8'h00);
      // Down count through zero.
      step(1, 0, 1, 1, 8'h02);
      repeat (3) step(1, 1, 0, 1, 8'h00);
      // Hold, then alternate direction.
      step(1, 0, 1, 0, 8'h05);
      repeat (4) step(1, 1, 1, 0, 8'h00);
      step(1, 1, 0, 0, 8'h00);
      step(1, 1, 0, 1, 8'h00);
      step(1, 1, 0, 0, 8'h00);
      // Cascade boundaries.
      step(1, 0, 1, 0, 8'h0F);
      step(1, 1, 0, 0, 8'h00);
      step(1, 0, 1, 1, 8'h10);
      step(1, 1, 0, 1, 8'h00);
      step(1, 0, 1, 1, 8'h00);
      step(1, 1, 0, 1, 8'h00);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) != 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 1),
              8'($urandom));
      end

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge cp);
      #1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
